rate_detector: RTL and testbench

RATE_DETECTOR -- requirements
Module: rate_detector

---
 rtl/rate_detect_pkg.sv | 21 ++
 rtl/rate_detector_edge_sync.sv | 35 +++
 rtl/rate_detector.sv | 158 +++++++++++++++
 tb/tb_rate_detector.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/rate_detect_pkg.sv
// Shared constants and state encoding for the rate_detector block.
package rate_detect_pkg;

  localparam logic [1:0] SPEED_SLOW = 2'b00;
  localparam logic [1:0] SPEED_MED  = 2'b01;
  localparam logic [1:0] SPEED_FAST = 2'b10;
  localparam logic [1:0] SPEED_MAX  = 2'b11;

  localparam int unsigned TH0_DEF  = 37500000;
  localparam int unsigned TH1_DEF  = 18750000;
  localparam int unsigned TH2_DEF  = 9375000;
  localparam int unsigned TMIN_DEF = 3125000;
  localparam int unsigned TMAX_DEF = 75000000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_TRACK = 2'd2
  } state_t;

endpackage

// File: rtl/rate_detector_edge_sync.sv
// Synchronizes div_clock into in_clock and flags either transition for one cycle.
module edge_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic in_clock,
  input  logic reset,
  input  logic async_in,
  output logic edge_pulse
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q, hist_d;

  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = async_in;
    for (int i = 1; i < int'(SYNC_STAGES); i++) begin
      sync_d[i] = sync_q[i-1];
    end
    hist_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge in_clock) begin
    if (reset) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  assign edge_pulse = sync_q[SYNC_STAGES-1] ^ hist_q;

endmodule

// File: rtl/rate_detector.sv
// Measures the half-period of div_clock in in_clock cycles and decodes a speed level.
// Build option: define RATE_DETECTOR_LOCK_EN to require two matching decodes for locked.
//
// state    | meaning
// ST_IDLE  | after reset or stall; next edge only starts the count
// ARMED    | counting, no measurement accepted yet
// TRACK    | at least one measurement accepted
module rate_detector
  import rate_detect_pkg::*;
#(
  parameter int unsigned CW          = 27,
  parameter int unsigned TH0         = TH0_DEF,
  parameter int unsigned TH1         = TH1_DEF,
  parameter int unsigned TH2         = TH2_DEF,
  parameter int unsigned TMIN        = TMIN_DEF,
  parameter int unsigned TMAX        = TMAX_DEF,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic          in_clock,
  input  logic          reset,
  input  logic          div_clock,
  output logic [1:0]    speed,
  output logic [CW-1:0] period,
  output logic          valid,
  output logic          new_meas,
  output logic          locked,
  output logic          stalled,
  output logic          err_fast
);

  localparam logic [CW-1:0] TH0_C  = CW'(TH0);
  localparam logic [CW-1:0] TH1_C  = CW'(TH1);
  localparam logic [CW-1:0] TH2_C  = CW'(TH2);
  localparam logic [CW-1:0] TMIN_C = CW'(TMIN);
  localparam logic [CW-1:0] TMAX_C = CW'(TMAX);

  logic          edge_det;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] period_q, period_d;
  logic [1:0]    speed_q, speed_d;
  logic [1:0]    dec;
  logic          valid_q, valid_d;
  logic          new_meas_q, new_meas_d;
  logic          stalled_q, stalled_d;
  logic          err_fast_q, err_fast_d;

  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_edge_sync (
    .in_clock   (in_clock),
    .reset      (reset),
    .async_in   (div_clock),
    .edge_pulse (edge_det)
  );

  always_comb begin
    if (cnt_q >= TH0_C)      dec = SPEED_SLOW;
    else if (cnt_q >= TH1_C) dec = SPEED_MED;
    else if (cnt_q >= TH2_C) dec = SPEED_FAST;
    else                     dec = SPEED_MAX;
  end

`ifdef RATE_DETECTOR_LOCK_EN
  logic lock_q, lock_d;
  logic pair_q, pair_d;
`endif

  always_comb begin
    state_d    = state_q;
    speed_d    = speed_q;
    period_d   = period_q;
    valid_d    = valid_q;
    stalled_d  = stalled_q;
    new_meas_d = 1'b0;
    err_fast_d = 1'b0;
`ifdef RATE_DETECTOR_LOCK_EN
    lock_d     = lock_q;
    pair_d     = pair_q;
`endif
    if (edge_det)               cnt_d = CW'(1);
    else if (cnt_q >= TMAX_C)   cnt_d = TMAX_C;
    else                        cnt_d = cnt_q + CW'(1);

    // An edge wins over the stall check, so m == TMAX is still a measurement.
    if (edge_det) begin
      stalled_d = 1'b0;
      if (state_q == ST_IDLE) begin
        state_d = ST_ARMED;
      end else if (cnt_q < TMIN_C) begin
        err_fast_d = 1'b1;
`ifdef RATE_DETECTOR_LOCK_EN
        lock_d = 1'b0;
        pair_d = 1'b0;
`endif
      end else begin
        speed_d    = dec;
        period_d   = cnt_q;
        valid_d    = 1'b1;
        new_meas_d = 1'b1;
        state_d    = ST_TRACK;
`ifdef RATE_DETECTOR_LOCK_EN
        lock_d = pair_q && (dec == speed_q);
        pair_d = 1'b1;
`endif
      end
    end else if (cnt_q == TMAX_C) begin
      stalled_d = 1'b1;
      valid_d   = 1'b0;
      state_d   = ST_IDLE;
`ifdef RATE_DETECTOR_LOCK_EN
      lock_d = 1'b0;
      pair_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge in_clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      speed_q    <= SPEED_SLOW;
      period_q   <= '0;
      valid_q    <= 1'b0;
      new_meas_q <= 1'b0;
      stalled_q  <= 1'b0;
      err_fast_q <= 1'b0;
`ifdef RATE_DETECTOR_LOCK_EN
      lock_q     <= 1'b0;
      pair_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      speed_q    <= speed_d;
      period_q   <= period_d;
      valid_q    <= valid_d;
      new_meas_q <= new_meas_d;
      stalled_q  <= stalled_d;
      err_fast_q <= err_fast_d;
`ifdef RATE_DETECTOR_LOCK_EN
      lock_q     <= lock_d;
      pair_q     <= pair_d;
`endif
    end
  end

  assign speed    = speed_q;
  assign period   = period_q;
  assign valid    = valid_q;
  assign new_meas = new_meas_q;
  assign stalled  = stalled_q;
  assign err_fast = err_fast_q;
`ifdef RATE_DETECTOR_LOCK_EN
  assign locked   = lock_q;
`else
  assign locked   = valid_q;
`endif

endmodule

// File: tb/tb_rate_detector.sv
// Directed bench for rate_detector with small thresholds; each vector toggles
// div_clock once and then watches the following gap cycles.
module tb_rate_detector;

  localparam int CW = 27;

  logic          in_clock = 1'b0;
  logic          reset;
  logic          div_clock;
  logic [1:0]    speed;
  logic [CW-1:0] period;
  logic          valid, new_meas, locked, stalled, err_fast;

  int total = 0;
  int bad   = 0;

  rate_detector #(
    .CW(CW), .TH0(375), .TH1(188), .TH2(94), .TMIN(31), .TMAX(750), .SYNC_STAGES(2)
  ) dut (
    .in_clock  (in_clock),
    .reset     (reset),
    .div_clock (div_clock),
    .speed     (speed),
    .period    (period),
    .valid     (valid),
    .new_meas  (new_meas),
    .locked    (locked),
    .stalled   (stalled),
    .err_fast  (err_fast)
  );

  always #5 in_clock = ~in_clock;

  typedef struct {
    int gap;   // cycles watched after this toggle (= next measured value)
    bit nw;    // this edge yields new_meas
    bit er;    // this edge yields err_fast
    int spd;
    int per;
    bit vld;
    bit lk;    // locked when the lock option is built in
    bit stl;
  } vec_t;

  vec_t tbl[11];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int exp_lock(input vec_t v);
`ifdef RATE_DETECTOR_LOCK_EN
    return int'(v.lk);
`else
    return int'(v.vld);
`endif
  endfunction

  // Toggle now, observe v.gap cycles; pulses must land exactly 3 samples after the toggle.
  task automatic do_edge(input string tag, input vec_t v);
    int new_cnt = 0, new_pos = -1, err_cnt = 0, err_pos = -1;
    div_clock = ~div_clock;
    for (int i = 1; i <= v.gap; i++) begin
      @(posedge in_clock); #1;
      if (new_meas === 1'b1) begin new_cnt++; if (new_pos < 0) new_pos = i; end
      if (err_fast === 1'b1) begin err_cnt++; if (err_pos < 0) err_pos = i; end
    end
    check({tag, " new_meas count"}, new_cnt, int'(v.nw));
    if (v.nw) check({tag, " new_meas latency"}, new_pos, 3);
    check({tag, " err_fast count"}, err_cnt, int'(v.er));
    if (v.er) check({tag, " err_fast latency"}, err_pos, 3);
    check({tag, " speed"},   int'(speed),   v.spd);
    check({tag, " period"},  int'(period),  v.per);
    check({tag, " valid"},   int'(valid),   int'(v.vld));
    check({tag, " locked"},  int'(locked),  exp_lock(v));
    check({tag, " stalled"}, int'(stalled), int'(v.stl));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " speed"},    int'(speed),    0);
    check({tag, " period"},   int'(period),   0);
    check({tag, " valid"},    int'(valid),    0);
    check({tag, " new_meas"}, int'(new_meas), 0);
    check({tag, " locked"},   int'(locked),   0);
    check({tag, " stalled"},  int'(stalled),  0);
    check({tag, " err_fast"}, int'(err_fast), 0);
  endtask

  initial begin
    int stall_pos;
    int stall_valid;
    int stall_lock;
    vec_t v;

    //            gap  nw er spd per  vld lk stl
    tbl[0]  = '{500, 0, 0, 0,   0, 0, 0, 0};
    tbl[1]  = '{500, 1, 0, 0, 500, 1, 0, 0};
    tbl[2]  = '{250, 1, 0, 0, 500, 1, 1, 0};
    tbl[3]  = '{250, 1, 0, 1, 250, 1, 0, 0};
    tbl[4]  = '{125, 1, 0, 1, 250, 1, 1, 0};
    tbl[5]  = '{125, 1, 0, 2, 125, 1, 0, 0};
    tbl[6]  = '{ 63, 1, 0, 2, 125, 1, 1, 0};
    tbl[7]  = '{ 63, 1, 0, 3,  63, 1, 0, 0};
    tbl[8]  = '{ 20, 1, 0, 3,  63, 1, 1, 0};
    tbl[9]  = '{ 20, 0, 1, 3,  63, 1, 0, 0};
    tbl[10] = '{ 20, 0, 1, 3,  63, 1, 0, 0};

    reset = 1'b1;
    div_clock = 1'b0;
    repeat (3) @(posedge in_clock);
    #1;
    check_all_zero("reset");
    reset = 1'b0;
    repeat (5) @(posedge in_clock);
    #1;

    for (int k = 0; k < 11; k++) begin
      do_edge($sformatf("vec%0d", k), tbl[k]);
    end

    // Last edge (vec10) pulsed at sample 3; stall must follow 750 cycles later.
    stall_pos = -1; stall_valid = -1; stall_lock = -1;
    for (int i = 21; i <= 800; i++) begin
      @(posedge in_clock); #1;
      if (stalled === 1'b1 && stall_pos < 0) begin
        stall_pos = i;
        stall_valid = int'(valid);
        stall_lock = int'(locked);
      end
    end
    check("stall position", stall_pos, 753);
    check("stall valid", stall_valid, 0);
    check("stall locked", stall_lock, 0);

    v = '{125, 0, 0, 3, 63, 0, 0, 0};
    do_edge("rearm", v);
    v = '{60, 1, 0, 2, 125, 1, 0, 0};
    do_edge("after stall", v);

    // Reset in the middle of a period.
    reset = 1'b1;
    div_clock = 1'b0;
    @(posedge in_clock); #1;
    check_all_zero("mid reset");
    @(posedge in_clock); #1;
    reset = 1'b0;

    v = '{125, 0, 0, 0, 0, 0, 0, 0};
    do_edge("post reset 1", v);
    v = '{750, 1, 0, 2, 125, 1, 0, 0};
    do_edge("post reset 2", v);
    // Edge coincides with the count reaching 750: accepted, no stall.
    v = '{30, 1, 0, 0, 750, 1, 0, 0};
    do_edge("tmax edge", v);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
